// File: rtl/morph_pkg.sv
// Shared types and constants for the morphology pass scheduler.
package morph_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        FLUSH = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int MAX_PASSES   = 4;

    localparam logic OP_ERODE  = 1'b0;
    localparam logic OP_DILATE = 1'b1;

    // Requested pass count minus one: 0 runs one pass, anything above MAX_PASSES runs MAX_PASSES.
    function automatic logic [1:0] clamp_passes_m1(input logic [2:0] n);
        if (n == 3'd0) return 2'd0;
        if (n > 3'(MAX_PASSES)) return 2'(MAX_PASSES - 1);
        return 2'(n - 3'd1);
    endfunction

endpackage

// File: rtl/morph_delay_line.sv
// LAT-deep shift of {valid, addr} that only advances on the datapath clock enable,
// so the write port stays aligned with the morphology pipeline output.
module morph_delay_line #(
    parameter int LAT = 2,
    parameter int AW  = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic [LAT-1:0] vld_q;
    logic [AW-1:0]  addr_q [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
        end else if (ce) begin
            vld_q[0]  <= in_valid;
            addr_q[0] <= in_addr;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_addr  = addr_q[LAT-1];

endmodule

// File: rtl/morph_pass_scheduler.sv
// Multi-pass erode/dilate scheduler: raster scan, latency-matched write-back and
// ping-pong buffer selection for one stored frame per start/done job.
//
// state | meaning
// IDLE  | waiting for start, latches pass count and op sequence
// SCAN  | raster read of the source buffer, one pixel per pix_ce
// FLUSH | drains the datapath for LAT enabled cycles, no reads
// NEXT  | swaps buffers, rewinds scan, selects next pass or finishes
// DONE  | one-cycle done pulse
module morph_pass_scheduler
    import morph_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int LAT      = 2,
    parameter int AW       = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    num_passes,
    input  logic [3:0]    op_seq,
    input  logic          hold,
    output logic          pix_ce,
    output logic [10:0]   hpos,
    output logic [10:0]   vpos,
    output logic          op_sel,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          buf_sel,
    output logic [1:0]    pass_idx,
    output logic          busy,
    output logic          done
);

    localparam int FCW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t         state, state_nxt;
    logic [1:0]     passes_m1;
    logic [3:0]     op_seq_q;
    logic [AW-1:0]  lin_addr;
    logic [FCW-1:0] flush_cnt;
    logic [1:0]     pass_nxt;
    logic           at_eol, last_pix, flush_tc, last_pass;
    logic           tap_valid;
    logic [AW-1:0]  tap_addr;

    assign at_eol    = (hpos == 11'(H_ACTIVE - 1));
    assign last_pix  = at_eol && (vpos == 11'(V_ACTIVE - 1));
    assign flush_tc  = (flush_cnt == '0);
    assign last_pass = (pass_idx == passes_m1);
    assign pass_nxt  = pass_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_ce    = 1'b0;
        rd_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                pix_ce = ~hold;
                rd_en  = ~hold;
                if (!hold && last_pix) state_nxt = FLUSH;
            end
            FLUSH: begin
                pix_ce = ~hold;
                if (!hold && flush_tc) state_nxt = NEXT;
            end
            NEXT:    state_nxt = last_pass ? DONE : SCAN;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Linear address tracks vpos*H_ACTIVE+hpos incrementally, avoiding a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos      <= '0;
            vpos      <= '0;
            lin_addr  <= '0;
            flush_cnt <= '0;
            pass_idx  <= '0;
            passes_m1 <= '0;
            op_seq_q  <= '0;
            op_sel    <= OP_ERODE;
            buf_sel   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    passes_m1 <= clamp_passes_m1(num_passes);
                    op_seq_q  <= op_seq;
                    op_sel    <= op_seq[0];
                    pass_idx  <= '0;
                    buf_sel   <= 1'b0;
                    hpos      <= '0;
                    vpos      <= '0;
                    lin_addr  <= '0;
                end
                SCAN: if (pix_ce) begin
                    if (last_pix) begin
                        flush_cnt <= FCW'(LAT - 1);
                    end else begin
                        lin_addr <= lin_addr + AW'(1);
                        if (at_eol) begin
                            hpos <= '0;
                            vpos <= vpos + 11'd1;
                        end else begin
                            hpos <= hpos + 11'd1;
                        end
                    end
                end
                FLUSH: if (pix_ce && !flush_tc) flush_cnt <= flush_cnt - FCW'(1);
                NEXT: begin
                    buf_sel  <= ~buf_sel;
                    hpos     <= '0;
                    vpos     <= '0;
                    lin_addr <= '0;
                    if (!last_pass) begin
                        pass_idx <= pass_nxt;
                        op_sel   <= op_seq_q[pass_nxt];
                    end
                end
                default: ;
            endcase
        end
    end

    morph_delay_line #(
        .LAT (LAT),
        .AW  (AW)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (pix_ce),
        .in_valid  (rd_en),
        .in_addr   (lin_addr),
        .out_valid (tap_valid),
        .out_addr  (tap_addr)
    );

    assign rd_addr = lin_addr;
    assign wr_en   = tap_valid & pix_ce;
    assign wr_addr = tap_addr;

endmodule

// File: tb/tb_morph_pass_scheduler.sv
// Directed and randomized jobs on a small 8x4 frame, compared against a
// per-pass read/write count and address model derived from the pass rules.
module tb_morph_pass_scheduler;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int LAT = 3;
    localparam int AW  = 5;
    localparam int N   = H * V;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    num_passes;
    logic [3:0]    op_seq;
    logic          hold;
    logic          pix_ce;
    logic [10:0]   hpos;
    logic [10:0]   vpos;
    logic          op_sel;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          buf_sel;
    logic [1:0]    pass_idx;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    morph_pass_scheduler #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .LAT      (LAT),
        .AW       (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_passes (num_passes),
        .op_seq     (op_seq),
        .hold       (hold),
        .pix_ce     (pix_ce),
        .hpos       (hpos),
        .vpos       (vpos),
        .op_sel     (op_sel),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .buf_sel    (buf_sel),
        .pass_idx   (pass_idx),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({pix_ce, hpos, vpos, op_sel, rd_en, rd_addr, wr_en, wr_addr,
                    buf_sel, pass_idx, busy, done});
    endfunction

    // Inputs are driven at the falling edge, outputs sampled 1 time unit later,
    // so each sample describes what the following rising edge will commit.
    task automatic run_job(input string tag, input logic [2:0] np, input logic [3:0] ops,
                           input int hold_pct, input bit directed_hold, input bit spam);
        int   eff;
        int   pass_rd[4];
        int   pass_wr[4];
        int   done_cnt = 0, bad_rd = 0, bad_wr = 0, bad_hold = 0, held = 0;
        int   ce_cnt = 0, first_rd = -1, first_wr = -1, cyc = 0, hold_left = 0;
        int   idle_busy = 0, wr_total = 0;
        bit   seen_done = 0, h1 = 0, h2 = 0, prev_hold = 0;
        logic prev_buf = 1'b0, fin_buf = 1'b0;
        logic [10:0]   prev_h = '0, prev_v = '0;
        logic [AW-1:0] prev_wa = '0;

        eff = (np == 3'd0) ? 1 : ((np > 3'd4) ? 4 : int'(np));
        for (int i = 0; i < 4; i++) begin
            pass_rd[i] = 0;
            pass_wr[i] = 0;
        end
        hold = 1'b0; num_passes = np; op_seq = ops; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && cyc < 3000) begin
            cyc++;
            if (directed_hold) begin
                if (!h1 && pass_rd[0] == 13) begin h1 = 1; hold_left = 5; end
                if (!h2 && pass_rd[0] == N) begin h2 = 1; hold_left = 2; end
                hold = (hold_left > 0);
                if (hold_left > 0) hold_left--;
            end else begin
                hold = ($urandom_range(99) < hold_pct);
            end
            if (spam) begin
                start = ($urandom_range(3) == 0);
                num_passes = 3'($urandom_range(7));
            end
            #1;
            if (prev_hold && buf_sel === prev_buf &&
                (hpos !== prev_h || vpos !== prev_v || wr_addr !== prev_wa)) bad_hold++;
            if (hold && (pix_ce !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0)) bad_hold++;
            if (hold) held++;
            if (rd_en === 1'b1) begin
                int e;
                e = pass_rd[pass_idx];
                if (rd_addr !== AW'(e) || hpos !== 11'(e % H) || vpos !== 11'(e / H) ||
                    op_sel !== ops[pass_idx] || buf_sel !== pass_idx[0] ||
                    int'(pass_idx) >= eff) bad_rd++;
                pass_rd[pass_idx]++;
                if (first_rd < 0) first_rd = ce_cnt;
            end
            if (wr_en === 1'b1) begin
                int e;
                e = pass_wr[pass_idx];
                if (wr_addr !== AW'(e) || op_sel !== ops[pass_idx] ||
                    buf_sel !== pass_idx[0] || int'(pass_idx) >= eff) bad_wr++;
                pass_wr[pass_idx]++;
                if (first_wr < 0) first_wr = ce_cnt;
            end
            if (pix_ce === 1'b1) ce_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                seen_done = 1;
                fin_buf = buf_sel;
                if (spam) start = 1'b1;
            end
            prev_hold = hold; prev_buf = buf_sel; prev_h = hpos; prev_v = vpos; prev_wa = wr_addr;
            @(negedge clk);
        end
        start = 1'b0; hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (busy !== 1'b0 || done !== 1'b0) idle_busy++;
            @(negedge clk);
        end
        for (int p = 0; p < 4; p++) wr_total += pass_wr[p];

        chk({tag, "_completed"}, 64'(seen_done), 64'd1);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("%s_reads_pass%0d", tag, p), 64'(pass_rd[p]), 64'((p < eff) ? N : 0));
            chk($sformatf("%s_writes_pass%0d", tag, p), 64'(pass_wr[p]), 64'((p < eff) ? N : 0));
        end
        chk({tag, "_write_total"}, 64'(wr_total), 64'(eff * N));
        chk({tag, "_read_order"}, 64'(bad_rd), 64'd0);
        chk({tag, "_write_order"}, 64'(bad_wr), 64'd0);
        chk({tag, "_hold_freeze"}, 64'(bad_hold), 64'd0);
        chk({tag, "_latency"}, 64'(first_wr - first_rd), 64'(LAT));
        chk({tag, "_buf_at_done"}, 64'(fin_buf), 64'(eff % 2));
        chk({tag, "_buf_after"}, 64'(buf_sel), 64'(eff % 2));
        chk({tag, "_idle_after"}, 64'(idle_busy), 64'd0);
        if (directed_hold) chk({tag, "_held_cycles"}, 64'(held), 64'd7);
    endtask

    initial begin
        int          busy_seen;
        int          rd1;
        int          cyc;
        logic [3:0]  r_ops;

        rst_n = 1'b0; start = 1'b0; hold = 1'b0; num_passes = '0; op_seq = '0;
        repeat (3) @(negedge clk);
        #1 chk("reset_outputs", all_outputs(), 64'd0);
        rst_n = 1'b1;

        busy_seen = 0;
        repeat (50) begin
            @(negedge clk);
            #1 if (busy !== 1'b0) busy_seen++;
        end
        chk("idle_no_busy", 64'(busy_seen), 64'd0);
        @(negedge clk);

        run_job("single", 3'd1, 4'b0001, 0, 1'b0, 1'b0);
        run_job("three", 3'd3, 4'b0110, 0, 1'b0, 1'b0);
        run_job("hold", 3'd1, 4'(($urandom)), 0, 1'b1, 1'b0);
        run_job("spam", 3'd1, 4'(($urandom)), 10, 1'b0, 1'b1);
        run_job("np0", 3'd0, 4'(($urandom)), 20, 1'b0, 1'b1);
        run_job("np7", 3'd7, 4'(($urandom)), 25, 1'b0, 1'b1);
        repeat (3) begin
            run_job("rand", 3'($urandom_range(7)), 4'(($urandom)), $urandom_range(40),
                    1'b0, 1'($urandom_range(1)));
        end

        // Reset during the second pass's flush of a two-pass job.
        r_ops = 4'(($urandom));
        hold = 1'b0; num_passes = 3'd2; op_seq = r_ops; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd1 = 0; cyc = 0;
        while (rd1 < N && cyc < 500) begin
            #1 if (rd_en === 1'b1 && pass_idx === 2'd1) rd1++;
            cyc++;
            @(negedge clk);
        end
        chk("rst_reached_flush", 64'(rd1), 64'(N));
        #1 chk("rst_in_flush_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job("post_rst", 3'd1, 4'(($urandom)), 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
